// File: rtl/cfg_loader_pkg.sv
// Shared types and helpers for the configuration bitstream loader.
package cfg_loader_pkg;

    // Loader control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } cfg_state_e;

    // Default host data word width.
    localparam int CFG_BYTE_W = 8;

    // Width of a counter that must hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cfg_piso.sv
// Parallel-in / serial-out byte register with a bits-left counter.
// Priority: clear, then load, then shift. Shifting fills with zeros, so the
// MSB reads 0 once the byte is exhausted.
module cfg_piso
    import cfg_loader_pkg::*;
#(
    parameter int BYTE_W = CFG_BYTE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [BYTE_W-1:0] din_i,
    input  logic              shift_i,
    output logic              msb_o,
    output logic              empty_o,
    output logic              last_o
);

    localparam int BLW = cnt_width(BYTE_W);

    logic [BYTE_W-1:0] sreg_q, sreg_d;
    logic [BLW-1:0]    left_q, left_d;

    // Next-state for the data register and its remaining-bit count.
    always_comb begin
        sreg_d = sreg_q;
        left_d = left_q;
        if (clr_i) begin
            sreg_d = '0;
            left_d = '0;
        end else if (load_i) begin
            // A load may coincide with the shift of the previous byte's last
            // bit; that bit is already on the output, so the load wins.
            sreg_d = din_i;
            left_d = BLW'(BYTE_W);
        end else if (shift_i && (left_q != '0)) begin
            sreg_d = {sreg_q[BYTE_W-2:0], 1'b0};
            left_d = left_q - BLW'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg_q <= '0;
            left_q <= '0;
        end else begin
            sreg_q <= sreg_d;
            left_q <= left_d;
        end
    end

    assign msb_o   = sreg_q[BYTE_W-1];
    assign empty_o = (left_q == '0);
    assign last_o  = (left_q == BLW'(1));

endmodule

// File: rtl/cfg_bitstream_loader.sv
// Configuration bitstream loader: takes host bytes over valid/ready,
// serializes them MSB-first into the configuration chain and counts exactly
// CHAIN_LEN shifted bits. All outputs are decoded from registers.
module cfg_bitstream_loader
    import cfg_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 288,
    parameter int BYTE_W    = CFG_BYTE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [BYTE_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              cfg_bit,
    output logic              cfg_shift_en,
    output logic              busy,
    output logic              cfg_done,
    output logic              cfg_err
);

    localparam int            CW       = cnt_width(CHAIN_LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(CHAIN_LEN - 1);

    cfg_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic piso_clr, piso_msb, piso_empty, piso_last;
    logic in_shift, do_shift, xfer, final_shift;

    assign in_shift     = (state_q == SHIFT);
    assign cfg_shift_en = in_shift && !piso_empty;

    // A new byte is wanted when the register is empty, or is on its last bit
    // and the chain still needs bits beyond that one. Once the final byte is
    // in flight this never rises again, so no surplus bytes are taken.
    assign din_ready = in_shift && (piso_empty || (piso_last && (cnt_q < LAST_IDX)));

    // Abort suppresses this cycle's shift and load inside the loader; the
    // registered shift enable cannot see abort and the partial chain is
    // abandoned anyway.
    assign do_shift    = cfg_shift_en && !abort;
    assign xfer        = din_ready && din_valid && !abort;
    assign final_shift = do_shift && (cnt_q == LAST_IDX);

    cfg_piso #(
        .BYTE_W (BYTE_W)
    ) u_piso (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (piso_clr),
        .load_i  (xfer),
        .din_i   (din),
        .shift_i (do_shift),
        .msb_o   (piso_msb),
        .empty_o (piso_empty),
        .last_o  (piso_last)
    );

    // Next-state, bit counter and sticky error decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        piso_clr = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = SHIFT;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    piso_clr = 1'b1;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d  = IDLE;
                    err_d    = 1'b1;
                    piso_clr = 1'b1;
                end else begin
                    if (do_shift) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (final_shift) begin
                        // Any bits remaining in the last byte are discarded.
                        state_d  = DONE;
                        piso_clr = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                piso_clr = 1'b1;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign busy     = in_shift;
    assign cfg_done = (state_q == DONE);
    assign cfg_err  = err_q;
    assign cfg_bit  = piso_msb;

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// Bench for cfg_bitstream_loader: queue-based behavioural model checked every
// cycle, randomized byte streams and gaps, plus literal expectations.
module tb_cfg_bitstream_loader;

    localparam int N = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, abort = 1'b0, din_valid = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_ready, cfg_bit, cfg_shift_en, busy, cfg_done, cfg_err;

    logic       start8 = 1'b0, abort8 = 1'b0, dv8 = 1'b0;
    logic [7:0] din8 = 8'h00;
    logic       rdy8, bit8, sh8, busy8, done8, err8;

    cfg_bitstream_loader #(.CHAIN_LEN(N), .BYTE_W(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .din(din),
        .din_valid(din_valid), .din_ready(din_ready), .cfg_bit(cfg_bit),
        .cfg_shift_en(cfg_shift_en), .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err));

    cfg_bitstream_loader #(.CHAIN_LEN(8), .BYTE_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .abort(abort8), .din(din8),
        .din_valid(dv8), .din_ready(rdy8), .cfg_bit(bit8),
        .cfg_shift_en(sh8), .busy(busy8), .cfg_done(done8), .cfg_err(err8));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", nm, $time);
    endtask

    // ---------------- behavioural model (20-bit chain) ----------------
    // mode: 0 idle, 1 loading, 2 complete. m_q holds the not-yet-shifted bits
    // of the byte currently in the loader.
    int m_mode = 0, m_cnt = 0;
    bit m_q[$];
    bit m_err = 1'b0;

    function automatic bit m_rdy();
        return (m_mode == 1) && ((m_q.size() == 0) || (m_q.size() == 1 && m_cnt < N - 1));
    endfunction

    always @(posedge clk or posedge reset) begin
        bit take;
        if (reset) begin
            m_mode = 0; m_cnt = 0; m_q.delete(); m_err = 1'b0;
        end else if (m_mode == 1) begin
            if (abort) begin
                m_mode = 0; m_err = 1'b1; m_q.delete();
            end else begin
                take = din_valid && m_rdy();
                if (m_q.size() > 0) begin
                    void'(m_q.pop_front());
                    m_cnt++;
                end
                if (take) for (int i = 7; i >= 0; i--) m_q.push_back(din[i]);
                if (m_cnt == N) begin
                    m_mode = 2; m_q.delete();
                end
            end
        end else if (start) begin
            m_mode = 1; m_cnt = 0; m_q.delete(); m_err = 1'b0;
        end
    end

    // ---------------- observation and per-cycle compare ----------------
    bit cmp_en = 1'b0;
    bit obs[$];
    int pulses = 0, xfers = 0;
    bit obs8[$];
    int p8 = 0, x8 = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", busy, m_mode == 1);
            chk("cfg_done", cfg_done, m_mode == 2);
            chk("cfg_err", cfg_err, m_err);
            chk("shift_en", cfg_shift_en, (m_mode == 1) && (m_q.size() > 0));
            chk("cfg_bit", cfg_bit, (m_q.size() > 0) ? m_q[0] : 1'b0);
            chk("din_ready", din_ready, m_rdy());
        end
        if (cfg_shift_en) begin obs.push_back(cfg_bit); pulses++; end
        if (din_valid && din_ready && !abort) xfers++;
        if (sh8) begin obs8.push_back(bit8); p8++; end
        if (dv8 && rdy8) x8++;
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] tx_q[$];
    bit stop_feed = 1'b0;

    function automatic logic [31:0] pack_obs();
        logic [31:0] v = '0;
        for (int i = 0; i < obs.size(); i++) v = {v[30:0], obs[i]};
        return v;
    endfunction

    // Expected chain stream: accepted bytes MSB-first, truncated to N bits.
    function automatic logic [31:0] exp_bits();
        logic [31:0] v = '0;
        int k = 0;
        for (int i = 0; i < tx_q.size(); i++)
            for (int j = 7; j >= 0; j--)
                if (k < N) begin v = {v[30:0], tx_q[i][j]}; k++; end
        return v;
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic feed(input int mingap, input int maxgap);
        for (int i = 0; i < tx_q.size() && !stop_feed; i++) begin
            int t;
            t = 0;
            din_valid = 1'b1;
            din = tx_q[i];
            while (!stop_feed) begin
                @(negedge clk);
                if (din_ready && !abort) begin
                    @(posedge clk); #1;
                    break;
                end
                @(posedge clk); #1;
                t++;
                if (t > 200) begin fail("feed_wait"); stop_feed = 1'b1; end
            end
            din_valid = 1'b0;
            din = 8'($urandom);
            repeat ($urandom_range(maxgap, mingap)) begin @(posedge clk); #1; end
        end
        din_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int t = 0;
        do begin @(negedge clk); t++; end while (!cfg_done && t < limit);
        if (!cfg_done) fail("wait_done");
    endtask

    task automatic rand_bytes();
        tx_q.delete();
        repeat (3) tx_q.push_back(8'($urandom));
    endtask

    task automatic run_load(input int mingap, input int maxgap, input bit hold);
        obs.delete(); pulses = 0; xfers = 0; stop_feed = 1'b0;
        pulse_start();
        @(negedge clk);
        chk("busy_after_start", busy, 1'b1);
        @(posedge clk); #1;
        feed(mingap, maxgap);
        if (hold) begin din_valid = 1'b1; din = 8'hEE; end
        wait_done(400);
        @(posedge clk); #1 din_valid = 1'b0;
    endtask

    task automatic chk_load(input string tag);
        chk({tag, "_bits"}, pack_obs(), exp_bits());
        chk({tag, "_pulses"}, pulses, N);
        chk({tag, "_xfers"}, xfers, 3);
        chk({tag, "_done"}, cfg_done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {din_ready, cfg_bit, cfg_shift_en, busy, cfg_done, cfg_err}, 6'b0);
        chk("rst_outs8", {rdy8, bit8, sh8, busy8, done8, err8}, 6'b0);
        @(posedge clk); #1 reset = 1'b0;
        cmp_en = 1'b1;

        // Basic gapless load; valid stays high after the last byte.
        tx_q.delete(); tx_q.push_back(8'hA5); tx_q.push_back(8'h3C); tx_q.push_back(8'hF0);
        run_load(0, 0, 1'b1);
        chk_load("basic");
        chk("basic_literal", pack_obs(), 32'h000A53CF);

        // Stalled load: 3-cycle gaps between single-cycle-valid bytes.
        run_load(3, 3, 1'b0);
        chk_load("stall");
        chk("stall_literal", pack_obs(), 32'h000A53CF);

        // Randomized streams with random gaps (each restarts from DONE).
        for (int r = 0; r < 6; r++) begin
            rand_bytes();
            run_load(0, 4, r[0]);
            chk_load("rand");
        end

        // Abort after 10 shifts.
        rand_bytes();
        obs.delete(); pulses = 0; xfers = 0; stop_feed = 1'b0;
        pulse_start();
        fork
            feed(0, 0);
            begin
                int t = 0;
                while (pulses < 10 && t < 200) begin @(posedge clk); t++; end
                if (t >= 200) fail("abort_wait");
                #1 abort = 1'b1;
                @(posedge clk); #1 abort = 1'b0;
                stop_feed = 1'b1;
            end
        join
        @(negedge clk);
        chk("abort_err", cfg_err, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", din_ready, 1'b0);
        chk("abort_done", cfg_done, 1'b0);
        rand_bytes();
        run_load(0, 2, 1'b0);
        chk_load("after_abort");
        chk("err_cleared", cfg_err, 1'b0);

        // Asynchronous reset after 5 shifts.
        rand_bytes();
        obs.delete(); pulses = 0; xfers = 0; stop_feed = 1'b0;
        pulse_start();
        fork
            feed(0, 0);
            begin
                int t = 0;
                while (pulses < 5 && t < 200) begin @(posedge clk); t++; end
                if (t >= 200) fail("reset_wait");
                @(negedge clk); #3 reset = 1'b1;
                #1;
                chk("midrst_outs", {din_ready, cfg_bit, cfg_shift_en, busy, cfg_done, cfg_err}, 6'b0);
                stop_feed = 1'b1;
                @(posedge clk); #1 reset = 1'b0;
            end
        join
        begin
            int p0;
            p0 = pulses;
            din_valid = 1'b1; din = 8'hFF;
            repeat (5) @(posedge clk);
            #1 din_valid = 1'b0;
            @(negedge clk);
            chk("midrst_noshift", pulses, p0);
            chk("midrst_idle", {busy, cfg_done}, 2'b00);
        end

        // Full load, then start ignored mid-load of a second load from DONE.
        rand_bytes();
        run_load(0, 1, 1'b0);
        chk_load("pre_restart");
        rand_bytes();
        fork
            run_load(0, 1, 1'b0);
            begin
                int t = 0;
                @(posedge clk);
                while (!(busy && pulses >= 7) && t < 300) begin @(posedge clk); t++; end
                if (t >= 300) fail("midstart_wait");
                #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
        join
        chk_load("restart");

        // CHAIN_LEN=8 instance: one byte fills the chain exactly.
        @(posedge clk); #1 start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        dv8 = 1'b1; din8 = 8'h81;
        begin
            int t = 0;
            do begin @(negedge clk); t++; end while (!rdy8 && t < 50);
            if (!rdy8) fail("edge_ready");
            @(posedge clk); #1 din8 = 8'hFF;
            t = 0;
            do begin @(negedge clk); t++; end while (!done8 && t < 50);
            if (!done8) fail("edge_done");
        end
        repeat (3) @(negedge clk);
        dv8 = 1'b0;
        begin
            logic [31:0] v = '0;
            for (int i = 0; i < obs8.size(); i++) v = {v[30:0], obs8[i]};
            chk("edge_bits", v, 32'h81);
        end
        chk("edge_pulses", p8, 8);
        chk("edge_xfers", x8, 1);
        chk("edge_done", done8, 1'b1);
        chk("edge_err", {busy8, err8}, 2'b00);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cfg_bitstream_loader.md
Name: cfg_bitstream_loader

Overview:
- Upstream stage of the configuration chain. Accepts configuration bytes from the host/boot interface through a valid/ready handshake.
- Serializes each byte MSB-first onto the serial input of the first 1-bit configuration cell in the chain.
- Generates the chain shift enable and counts exactly CHAIN_LEN shifted bits, then reports done.
- Top level gates the configuration-chain clock with cfg_shift_en, so the chain advances only on enabled cycles.

Parameters:
- CHAIN_LEN, 288: total configuration bits in the chain (number of cells); must be >= 1.
- BYTE_W, 8: width of host data word.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE or DONE.
- abort  input  1  cancels an in-progress load.
- din  input  BYTE_W  configuration byte, MSB shifted first.
- din_valid  input  1  din is valid.
- din_ready  output  1  loader accepts din this cycle.
- cfg_bit  output  1  serial bit into the first chain cell's data input.
- cfg_shift_en  output  1  chain advances one position on this cycle's edge.
- busy  output  1  high in SHIFT state.
- cfg_done  output  1  high in DONE state (exactly CHAIN_LEN bits shifted).
- cfg_err  output  1  sticky; set by abort during SHIFT, cleared by the next accepted start.

Behaviour:
- Reset (asynchronous, active-high; all outputs low next cycle onward):
  - state=IDLE, shift register=0, bits_left=0, bit_count=0, cfg_err=0.
  - Hence din_ready=0, cfg_bit=0, cfg_shift_en=0, busy=0, cfg_done=0.
  - Reset mid-load abandons the load; the partial chain contents are not this block's concern.
- States: IDLE, SHIFT, DONE.
  - IDLE --start--> SHIFT: clear bit_count and bits_left; clear cfg_err.
  - SHIFT --(bit_count reaches CHAIN_LEN)--> DONE.
  - SHIFT --abort--> IDLE with cfg_err=1. abort takes priority over a same-cycle shift, load or completion: no shift occurs that cycle.
  - DONE --start--> SHIFT (reload, same clearing as from IDLE).
  - start in SHIFT is ignored. abort in IDLE/DONE is ignored.
- Serialization:
  - cfg_bit = shift-register MSB.
  - cfg_shift_en = (state==SHIFT) && (bits_left!=0).
  - Each enabled cycle: shift register shifts left, filling 0; bits_left decrements; bit_count increments.
- Handshake:
  - din_ready = (state==SHIFT) && (bits_left<=1) && (bits still needed after the current one > 0).
  - Transfer occurs when din_valid && din_ready. The shift register loads din and bits_left=BYTE_W at that edge.
  - Loading in the same cycle as the last bit of the previous byte gives gapless streaming: one bit per cycle with din_valid held high.
  - Latency: byte accepted at edge N; its MSB appears on cfg_bit with cfg_shift_en high in cycle N+1.
  - If din_valid is low while bits_left==0, cfg_shift_en stays low (stall); the chain holds.
  - din is don't-care when din_valid is low. din_valid may drop without a transfer.
- Completion:
  - When the shift that makes bit_count==CHAIN_LEN occurs, the next state is DONE.
  - Bits left in the final byte are discarded (CHAIN_LEN not a multiple of BYTE_W).
  - din_ready is never asserted for bytes beyond ceil(CHAIN_LEN/BYTE_W).
- Widths: bit_count is $clog2(CHAIN_LEN+1) bits, with no wrap possible. bits_left is $clog2(BYTE_W+1) bits.
- All outputs are decoded from registers only; no input-to-output combinational path except none (din_ready is register-only).

Decomposition:
- Package cfg_loader_pkg holds:
  - state enum (IDLE, SHIFT, DONE);
  - CFG_BYTE_W constant = 8;
  - a helper function for counter width ($clog2(n+1)).
- One natural sub-module: cfg_piso (parallel-in/serial-out byte register plus bits_left counter, with load/shift/empty signals).
- FSM, bit_count, handshake and error flag stay in cfg_bitstream_loader.

Test Plan (bench uses CHAIN_LEN=20):
- Basic load: start, then bytes 0xA5, 0x3C, 0xF0 with valid held -> cfg_bit on the 20 consecutive shift_en cycles = 1010_0101_0011_1100_1111; din_ready high for exactly 3 transfers; cfg_done=1 on cycle after the 20th shift; low nibble of 0xF0 dropped.
- Stall: 1-cycle-valid bytes with 3-cycle gaps -> cfg_shift_en low during gaps; total shift_en pulses still 20; bit sequence unchanged.
- Abort: abort asserted after 10 shifts -> no shift that cycle; IDLE; cfg_err=1; busy=0; din_ready=0. A subsequent start clears cfg_err.
- Async reset mid-load after 5 shifts -> all outputs 0 immediately; IDLE; no further shift_en until a new start.
- Restart from DONE: start in DONE -> busy=1, bit_count restarts; second full load yields 20 further pulses. start during SHIFT -> no effect on count.
- Edge CHAIN_LEN=8, one byte 0x81 -> 8 pulses, bits 1000_0001, done; din_ready never high again.
